// File: rtl/dmem_access_ctrl.sv
// Memory-stage data access controller: fault checks on the MMU's data-side result,
// then either a precise exception response or a single req/ack bus transaction.
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_vaddr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   mmu_phy_addr,
    input  logic                mmu_miss,
    input  logic                mmu_illegal,
    input  logic                mmu_invalid,
    input  logic                mmu_dirty,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stall,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                exc_valid,
    output logic [4:0]          exc_code,
    output logic                exc_refill,
    output logic [ADDR_W-1:0]   exc_badvaddr
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_t;

    state_t r_state;

    logic            w_misaligned;
    logic            w_fault;
    logic            w_refill;
    logic [4:0]      w_exc_code;
    logic [BE_W-1:0] w_be;
    logic            w_req_live;
    logic            w_stall;
    logic            w_unused;

    // The low physical address bits are replaced by the word-aligned bus address.
    assign w_unused = ^mmu_phy_addr[1:0];

    // NOTE: every variable gets a default at the top of the block, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_misaligned = 1'b0;
        w_be         = '1;
        case (req_size)
            2'd0: begin
                w_misaligned = 1'b0;
                w_be         = BE_W'(1) << req_vaddr[1:0];
            end
            2'd1: begin
                w_misaligned = req_vaddr[0];
                w_be         = BE_W'(2'b11) << req_vaddr[1:0];
            end
            default: begin
                w_misaligned = |req_vaddr[1:0];
                w_be         = '1;
            end
        endcase
    end

    // Faults in priority order: alignment, segment, refill, invalid entry, clean page.
    always_comb begin
        w_fault    = 1'b1;
        w_refill   = 1'b0;
        w_exc_code = '0;
        if (w_misaligned || mmu_invalid) begin
            w_exc_code = req_we ? EXC_ADES : EXC_ADEL;
        end else if (mmu_miss) begin
            w_exc_code = req_we ? EXC_TLBS : EXC_TLBL;
            w_refill   = 1'b1;
        end else if (mmu_illegal) begin
            w_exc_code = req_we ? EXC_TLBS : EXC_TLBL;
        end else if (req_we && !mmu_dirty) begin
            w_exc_code = EXC_MOD;
        end else begin
            w_fault = 1'b0;
        end
    end

    assign w_req_live = (r_state == IDLE) && req_valid && !flush;

    // A flushed op in BUSY releases the pipeline at once; the bus side drains on its own.
    assign w_stall = (w_req_live && !w_fault) ||
                     ((r_state == BUSY) && !bus_ack && !flush);
    assign stall   = w_stall & rst;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the block is order independent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= '0;
            exc_refill   <= 1'b0;
            exc_badvaddr <= '0;
        end else begin
            resp_valid <= 1'b0;
            exc_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_live) begin
                        if (w_fault) begin
                            resp_valid   <= 1'b1;
                            exc_valid    <= 1'b1;
                            exc_code     <= w_exc_code;
                            exc_refill   <= w_refill;
                            exc_badvaddr <= req_vaddr;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {mmu_phy_addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= w_be;
                            bus_wdata <= req_wdata;
                            r_state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_state <= IDLE;
                        if (!flush) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= bus_rdata;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
